// File: rtl/load_store_unit.sv
// Load/store unit between a core request port and a single-port, registered-read data memory.
// Handles byte/halfword/word loads and stores; sub-word stores use a read-modify-write.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              mem_we,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR       = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              write_r;
  logic [1:0]        size_r;
  logic              signed_r;
  logic [ADDR_W+1:0] addr_r;
  logic [31:0]       rdata_r;
  logic [31:0]       mem_wd_r;
  logic              err_r;
  logic              req_err_s;
  logic [31:0]       load_val_s;
  logic [31:0]       merged_s;

  // Reserved size, or a halfword/word whose address is not naturally aligned.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign req_err_s = is_bad_req(req_size, req_addr[1:0]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; only word stores skip the read phase.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!req_valid) begin
          state_s = IDLE;
        end else if (req_err_s) begin
          state_s = RESP;
        end else if (req_write && (req_size == 2'b10)) begin
          state_s = WR;
        end else begin
          state_s = RD_ISSUE;
        end
      end
      RD_ISSUE: state_s = RD_WAIT;
      RD_WAIT: begin
        if (write_r) begin
          state_s = WR;
        end else begin
          state_s = RESP;
        end
      end
      WR:      state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Lane extraction for loads (little-endian lanes).
  always_comb begin
    load_val_s = mem_rd;
    case (size_r)
      2'b00: begin
        case (addr_r[1:0])
          2'b00:   load_val_s[7:0] = mem_rd[7:0];
          2'b01:   load_val_s[7:0] = mem_rd[15:8];
          2'b10:   load_val_s[7:0] = mem_rd[23:16];
          default: load_val_s[7:0] = mem_rd[31:24];
        endcase
        load_val_s[31:8] = {24{signed_r & load_val_s[7]}};
      end
      2'b01: begin
        if (addr_r[1]) begin
          load_val_s[15:0] = mem_rd[31:16];
        end else begin
          load_val_s[15:0] = mem_rd[15:0];
        end
        load_val_s[31:16] = {16{signed_r & load_val_s[15]}};
      end
      default: load_val_s = mem_rd;
    endcase
  end

  // Merge of the store data into the word read back; mem_wd_r still holds raw wdata here.
  always_comb begin
    merged_s = mem_rd;
    if (size_r == 2'b00) begin
      case (addr_r[1:0])
        2'b00:   merged_s[7:0]   = mem_wd_r[7:0];
        2'b01:   merged_s[15:8]  = mem_wd_r[7:0];
        2'b10:   merged_s[23:16] = mem_wd_r[7:0];
        default: merged_s[31:24] = mem_wd_r[7:0];
      endcase
    end else if (addr_r[1]) begin
      merged_s[31:16] = mem_wd_r[15:0];
    end else begin
      merged_s[15:0] = mem_wd_r[15:0];
    end
  end

  // Request latch, write-data/merge register and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_r  <= 1'b0;
      size_r   <= 2'b00;
      signed_r <= 1'b0;
      addr_r   <= '0;
      mem_wd_r <= 32'h0000_0000;
      rdata_r  <= 32'h0000_0000;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            write_r  <= req_write;
            size_r   <= req_size;
            signed_r <= req_signed;
            addr_r   <= req_addr[ADDR_W+1:0];
            mem_wd_r <= req_wdata;
            if (req_err_s) begin
              rdata_r <= 32'h0000_0000;
              err_r   <= 1'b1;
            end
          end
        end
        RD_WAIT: begin
          if (write_r) begin
            mem_wd_r <= merged_s;
          end else begin
            rdata_r <= load_val_s;
            err_r   <= 1'b0;
          end
        end
        WR: begin
          rdata_r <= 32'h0000_0000;
          err_r   <= 1'b0;
        end
        default: begin
          rdata_r <= rdata_r;
        end
      endcase
    end
  end

  assign busy     = (state_r != IDLE);
  assign done     = (state_r == RESP);
  assign mem_we   = (state_r == WR);
  assign mem_addr = addr_r[ADDR_W+1:2];
  assign mem_wd   = mem_wd_r;
  assign rdata    = rdata_r;
  assign err      = err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:1023];
  logic        restore;
  int          n_checks;
  int          n_errors;

  load_store_unit #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: one-cycle registered read; restore reloads the preset words.
  always @(posedge clk) begin
    if (restore) begin
      mem[1] <= 32'h8899_AABB;
      mem[2] <= 32'h0000_0000;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wd;
    end
    mem_rd <= mem[mem_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd, input logic hold,
                         output int cyc, output int we_cnt, output logic [31:0] we_addr,
                         output logic [31:0] we_wd, output logic [31:0] rd, output logic er,
                         output logic [31:0] ma, output logic idle_busy);
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    cyc = 0; we_cnt = 0; we_addr = 32'h0; we_wd = 32'h0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!hold) req_valid = 1'b0;
      if (mem_we) begin
        we_cnt++;
        we_addr = {22'b0, mem_addr};
        we_wd   = mem_wd;
      end
    end while (!done && cyc < 20);
    rd = rdata;
    er = err;
    ma = {22'b0, mem_addr};
    @(posedge clk); #1;
    idle_busy = busy;
    req_valid = 1'b0;
  endtask

  int          cyc, we_cnt;
  logic [31:0] we_addr, we_wd, rd, ma;
  logic        er, ib;
  logic        saw_done;

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b1; restore = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 restore = 1'b0;
    check_val("rst_busy", {31'b0, busy}, 32'h0);
    check_val("rst_done", {31'b0, done}, 32'h0);
    check_val("rst_err", {31'b0, err}, 32'h0);
    check_val("rst_we", {31'b0, mem_we}, 32'h0);
    check_val("rst_rdata", rdata, 32'h0);
    check_val("rst_maddr", {22'b0, mem_addr}, 32'h0);
    check_val("rst_wd", mem_wd, 32'h0);

    // LB signed 0x7, accepted on the first edge after reset release.
    @(negedge clk) rst_n = 1'b1;
    run_req(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 1'b0, cyc, we_cnt, we_addr, we_wd, rd, er, ma, ib);
    check_val("lb_cyc", cyc, 32'd3);
    check_val("lb_rdata", rd, 32'hFFFF_FF88);
    check_val("lb_maddr", ma, 32'd1);
    check_val("lb_we", we_cnt, 32'd0);
    check_val("lb_err", {31'b0, er}, 32'h0);

    run_req(1'b0, 2'b01, 1'b0, 32'h4, 32'h0, 1'b0, cyc, we_cnt, we_addr, we_wd, rd, er, ma, ib);
    check_val("lhu_rdata", rd, 32'h0000_AABB);
    run_req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 1'b0, cyc, we_cnt, we_addr, we_wd, rd, er, ma, ib);
    check_val("lh_rdata", rd, 32'hFFFF_8899);
    check_val("lh_cyc", cyc, 32'd3);

    run_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h1234_5677, 1'b0, cyc, we_cnt, we_addr, we_wd, rd, er, ma, ib);
    check_val("sb_cyc", cyc, 32'd4);
    check_val("sb_we", we_cnt, 32'd1);
    check_val("sb_waddr", we_addr, 32'd1);
    check_val("sb_wd", we_wd, 32'h8899_77BB);
    check_val("sb_rdata", rd, 32'h0);

    run_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 1'b1, cyc, we_cnt, we_addr, we_wd, rd, er, ma, ib);
    check_val("sw_cyc", cyc, 32'd2);
    check_val("sw_we", we_cnt, 32'd1);
    check_val("sw_waddr", we_addr, 32'd2);
    check_val("sw_wd", we_wd, 32'hDEAD_BEEF);
    check_val("sw_idle", {31'b0, ib}, 32'h0);
    check_val("sw_mem", mem[2], 32'hDEAD_BEEF);

    run_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1'b0, cyc, we_cnt, we_addr, we_wd, rd, er, ma, ib);
    check_val("lw_mis_cyc", cyc, 32'd1);
    check_val("lw_mis_err", {31'b0, er}, 32'h1);
    check_val("lw_mis_we", we_cnt, 32'd0);
    run_req(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, cyc, we_cnt, we_addr, we_wd, rd, er, ma, ib);
    check_val("rsv_cyc", cyc, 32'd1);
    check_val("rsv_err", {31'b0, er}, 32'h1);
    check_val("rsv_we", we_cnt, 32'd0);

    // LBU after an error clears err; word 1 now holds the SB result.
    run_req(1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 1'b0, cyc, we_cnt, we_addr, we_wd, rd, er, ma, ib);
    check_val("lbu_rdata", rd, 32'h0000_00BB);
    check_val("lbu_err", {31'b0, er}, 32'h0);

    // High address bits wrap onto word 2.
    run_req(1'b0, 2'b10, 1'b0, 32'h1008, 32'h0, 1'b0, cyc, we_cnt, we_addr, we_wd, rd, er, ma, ib);
    check_val("wrap_maddr", ma, 32'd2);
    check_val("wrap_rdata", rd, 32'hDEAD_BEEF);

    // SH with reset asserted during WR.
    restore = 1'b1;
    @(posedge clk); #1 restore = 1'b0;
    req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h4; req_wdata = 32'h0000_5555; req_valid = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc++;
    end while (!mem_we && cyc < 10);
    check_val("sh_at_wr", {31'b0, mem_we}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_val("sh_rst_we", {31'b0, mem_we}, 32'h0);
    check_val("sh_rst_busy", {31'b0, busy}, 32'h0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check_val("sh_rst_done", {31'b0, saw_done}, 32'h0);
    check_val("sh_rst_mem", mem[1], 32'h8899_AABB);

    @(negedge clk) rst_n = 1'b1;
    run_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, cyc, we_cnt, we_addr, we_wd, rd, er, ma, ib);
    check_val("post_lw_rdata", rd, 32'h8899_AABB);
    check_val("post_lw_cyc", cyc, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
